// File: rtl/pla_lut_engine.sv
// pla_lut_engine
//
// Reloadable truth-table engine. An IN_W-input, OUT_W-output table lives in a
// register file that is reloaded word by word through a streaming config
// port. Input vectors are looked up through a valid/ready pipeline that is
// LAT (1 or 2) stages deep. A saturating counter accumulates the Hamming
// distance between successive output words, as a switching-activity measure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start             one-cycle reload request (honoured only in RUN)
//   cfg_valid/cfg_ready   config word handshake; cfg_ready is high in LOAD
//   cfg_data              table word, written in address order 0 .. 2^IN_W-1
//   in_valid/in_ready     input vector handshake
//   in_data               input vector (table address)
//   out_valid/out_ready   result handshake
//   out_data              table[in_data]; changes only when the output register loads
//   toggle_clr            synchronous clear of toggle_cnt (wins over an increment)
//   toggle_cnt            saturating sum of popcount(new_word ^ out_data)

module pla_lut_engine #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 28,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             toggle_clr,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int DEPTH = 1 << IN_W;
    localparam int PC_W  = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        LOAD
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  ptr;
    logic [OUT_W-1:0] lut [DEPTH];

    logic             out_stage_ready;
    logic             accept;
    logic             load_en;
    logic [OUT_W-1:0] load_word;
    logic             pipe_empty;

    logic [OUT_W-1:0] diff;
    logic [PC_W-1:0]  pop;
    logic [CNT_W:0]   sum;

    // The output register can take a new word when it is empty or being consumed.
    assign out_stage_ready = ~out_valid | out_ready;
    assign accept          = in_valid & in_ready;
    assign cfg_ready       = (state == LOAD);

    // Pipeline front end. With LAT=1 the table is read at acceptance and the
    // result goes straight into the output register. With LAT=2 an address
    // stage sits in front and the table is read as that stage advances.
    generate
        if (LAT == 2) begin : g_lat2
            logic            s1_valid;
            logic [IN_W-1:0] s1_data;

            assign in_ready   = (state == RUN) & (~s1_valid | out_stage_ready);
            assign load_en    = s1_valid & out_stage_ready;
            assign load_word  = lut[s1_data];
            assign pipe_empty = ~s1_valid & ~out_valid;

            // The address register only loads on an accepted vector so it stays
            // quiet during idle and backpressure cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else begin
                    if (~s1_valid | out_stage_ready) begin
                        s1_valid <= accept;
                    end
                    if (accept) begin
                        s1_data <= in_data;
                    end
                end
            end
        end else begin : g_lat1
            assign in_ready   = (state == RUN) & out_stage_ready;
            assign load_en    = accept;
            assign load_word  = lut[in_data];
            assign pipe_empty = ~out_valid;
        end
    endgenerate

    // Output register. out_data is written only on a real load, never on
    // stall or idle cycles, so downstream logic sees no spurious switching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_stage_ready) begin
                out_valid <= load_en;
            end
            if (load_en) begin
                out_data <= load_word;
            end
        end
    end

    // Hamming distance between the word about to be loaded and the current
    // output, added one bit wider than the counter so overflow is visible.
    always_comb begin
        diff = load_word ^ out_data;
        pop  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pop = pop + PC_W'(diff[i]);
        end
        sum = {1'b0, toggle_cnt} + (CNT_W+1)'(pop);
    end

    // Saturating toggle counter; a clear discards any coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (toggle_clr) begin
            toggle_cnt <= '0;
        end else if (load_en) begin
            toggle_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    // Reload sequencer. DRAIN holds off new vectors until every stage is
    // empty so no lookup ever sees a half-written table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            ptr   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (cfg_start) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        if (ptr == IN_W'(DEPTH - 1)) begin
                            ptr   <= '0;
                            state <= RUN;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Table storage. Reset clears every entry, which also discards a
    // partially completed reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if ((state == LOAD) && cfg_valid) begin
            lut[ptr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_pla_lut_engine.sv
// tb_pla_lut_engine
//
// Drives two engines from one config stream: dut_a (LAT=1, CNT_W=16) and
// dut_b (LAT=2, CNT_W=4). Both receive identical table reloads; each has its
// own lookup port. Expected results are queued when a vector is accepted and
// compared when the engine delivers a result; a toggle model follows the
// delivered words.

module tb_pla_lut_engine;

    localparam int IN_W  = 5;
    localparam int OUT_W = 28;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             clr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_start;
    logic             cfg_valid;
    logic [OUT_W-1:0] cfg_data;

    logic             in_valid   [2];
    logic [IN_W-1:0]  in_data    [2];
    logic             out_ready  [2];
    logic             toggle_clr [2];

    logic             cfg_ready_a, cfg_ready_b;
    logic             in_ready_a, in_ready_b;
    logic             out_valid_a, out_valid_b;
    logic [OUT_W-1:0] out_data_a, out_data_b;
    logic [15:0]      tog_a;
    logic [3:0]       tog_b;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;

    logic [OUT_W-1:0] mtab [DEPTH];
    exp_t             q0[$];
    exp_t             q1[$];
    int               exp_tog  [2];
    logic [OUT_W-1:0] last_out [2];
    int               pops     [2];

    pla_lut_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .cfg_data(cfg_data),
        .in_valid(in_valid[0]), .in_ready(in_ready_a), .in_data(in_data[0]),
        .out_valid(out_valid_a), .out_ready(out_ready[0]), .out_data(out_data_a),
        .toggle_clr(toggle_clr[0]), .toggle_cnt(tog_a)
    );

    pla_lut_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .cfg_data(cfg_data),
        .in_valid(in_valid[1]), .in_ready(in_ready_b), .in_data(in_data[1]),
        .out_valid(out_valid_b), .out_ready(out_ready[1]), .out_data(out_data_b),
        .toggle_clr(toggle_clr[1]), .toggle_cnt(tog_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic inRdy(input int d);
        return (d == 0) ? in_ready_a : in_ready_b;
    endfunction

    function automatic logic outVld(input int d);
        return (d == 0) ? out_valid_a : out_valid_b;
    endfunction

    function automatic logic [OUT_W-1:0] outDat(input int d);
        return (d == 0) ? out_data_a : out_data_b;
    endfunction

    function automatic int satMax(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    function automatic int popcnt(input logic [OUT_W-1:0] v);
        int c = 0;
        for (int i = 0; i < OUT_W; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int qSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Table contents used by the reloads.
    function automatic logic [OUT_W-1:0] tableWord(input int pat, input int a);
        logic [IN_W-1:0] a5;
        a5 = IN_W'(a);
        case (pat)
            0:       return {23'b0, a5};
            1:       return {a5, 18'h2AAAA, a5};
            2:       return a5[0] ? 28'hFFFFFFF : 28'h0;
            default: return ~{23'b0, a5};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scoreOutput(input int d);
        exp_t e;
        int   nt;
        int   sz;
        sz = qSize(d);
        checkOutput($sformatf("sb_nonempty%0d", d), 32'(sz > 0), 1);
        if (sz > 0) begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            checkOutput($sformatf("out_data%0d", d), 32'(outDat(d)), 32'(e.data));
            if (e.clr) begin
                exp_tog[d] = 0;
            end else begin
                nt = exp_tog[d] + popcnt(e.data ^ last_out[d]);
                exp_tog[d] = (nt > satMax(d)) ? satMax(d) : nt;
            end
            last_out[d] = e.data;
            pops[d]++;
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle: a handshake visible here
    // completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (in_valid[d] && inRdy(d)) begin
                    if (d == 0) q0.push_back('{data: mtab[in_data[d]], clr: toggle_clr[d]});
                    else        q1.push_back('{data: mtab[in_data[d]], clr: toggle_clr[d]});
                end
                if (outVld(d) && out_ready[d]) scoreOutput(d);
            end
        end
    end

    task automatic idleInputs();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]   = 1'b0;
            in_data[d]    = '0;
            out_ready[d]  = 1'b1;
            toggle_clr[d] = 1'b0;
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) mtab[i] = '0;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            exp_tog[d]  = 0;
            last_out[d] = '0;
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        idleInputs();
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer one vector and hold it until accepted (bounded).
    task automatic applyStimulus(input int d, input logic [IN_W-1:0] data);
        logic acc;
        int   n;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = inRdy(d);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid[d] = 1'b0;
        checkOutput($sformatf("accept%0d", d), 32'(acc), 1);
    endtask

    task automatic waitDrain(input int d);
        int n = 0;
        while ((qSize(d) != 0 || outVld(d)) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("drain%0d", d), 32'(qSize(d)), 0);
    endtask

    task automatic startCfg();
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic waitCfgReady();
        int n = 0;
        while (!(cfg_ready_a && cfg_ready_b) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("cfg_ready_both", 32'({cfg_ready_a, cfg_ready_b}), 32'b11);
    endtask

    task automatic loadWords(input int pat, input int count, input bit gaps);
        for (int a = 0; a < count; a++) begin
            if (gaps && (a % 3 == 1)) begin
                cfg_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            cfg_valid = 1'b1;
            cfg_data  = tableWord(pat, a);
            @(posedge clk);
            #1;
            mtab[a] = tableWord(pat, a);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic loadTable(input int pat, input bit gaps);
        startCfg();
        waitCfgReady();
        loadWords(pat, DEPTH, gaps);
        checkOutput("load_done", 32'({cfg_ready_a, cfg_ready_b}), 0);
    endtask

    initial begin
        int t0;
        int p0;
        int stall_tog;

        rst_n = 1'b0;
        idleInputs();
        resetModel();
        pops[0] = 0;
        pops[1] = 0;
        applyReset();

        // Reset state.
        checkOutput("rst_cfg_ready", 32'({cfg_ready_a, cfg_ready_b}), 0);
        checkOutput("rst_in_ready", 32'({in_ready_a, in_ready_b}), 32'b11);
        checkOutput("rst_out_valid", 32'({out_valid_a, out_valid_b}), 0);
        checkOutput("rst_out_data", 32'(out_data_a | out_data_b), 0);
        checkOutput("rst_tog", 32'({tog_a, tog_b}), 0);

        // Lookup on the reset (all-zero) table, and latency of each depth.
        applyStimulus(0, 5'h1F);
        checkOutput("lat1_valid", 32'(out_valid_a), 1);
        checkOutput("lat1_data", 32'(out_data_a), 0);
        waitDrain(0);
        checkOutput("lat1_tog", 32'(tog_a), 0);
        applyStimulus(1, 5'h1F);
        checkOutput("lat2_valid_early", 32'(out_valid_b), 0);
        @(posedge clk);
        #1;
        checkOutput("lat2_valid", 32'(out_valid_b), 1);
        waitDrain(1);

        // Identity reload; DRAIN lasts one cycle when the pipeline is empty.
        startCfg();
        checkOutput("drain_cfg_ready", 32'(cfg_ready_a), 0);
        @(posedge clk);
        #1;
        checkOutput("cfg_ready_1cyc", 32'(cfg_ready_a), 1);
        waitCfgReady();
        loadWords(0, DEPTH, 1'b0);
        checkOutput("load_done", 32'({cfg_ready_a, cfg_ready_b}), 0);

        // Back-to-back stream through the LAT=1 engine.
        t0 = cyc;
        p0 = pops[0];
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, IN_W'(a));
        checkOutput("throughput", 32'(cyc - t0), 32);
        waitDrain(0);
        checkOutput("stream_pops", 32'(pops[0] - p0), 32);
        checkOutput("tog57", 32'(tog_a), 57);
        checkOutput("tog_model_a", 32'(tog_a), 32'(exp_tog[0]));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_data", 32'(out_data_a), 31);

        // Backpressure on the LAT=2 engine.
        p0 = pops[1];
        out_ready[1] = 1'b0;
        applyStimulus(1, 5'd5);
        applyStimulus(1, 5'd6);
        stall_tog = exp_tog[1] + popcnt(mtab[5] ^ last_out[1]);
        if (stall_tog > 15) stall_tog = 15;
        in_valid[1] = 1'b1;
        in_data[1]  = 5'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready_b), 0);
            checkOutput("stall_valid", 32'(out_valid_b), 1);
            checkOutput("stall_data", 32'(out_data_b), 32'(mtab[5]));
            checkOutput("stall_tog", 32'(tog_b), 32'(stall_tog));
            @(posedge clk);
            #1;
        end
        out_ready[1] = 1'b1;
        applyStimulus(1, 5'd7);
        waitDrain(1);
        checkOutput("stall_pops", 32'(pops[1] - p0), 3);
        checkOutput("stall_tog_end", 32'(tog_b), 32'(exp_tog[1]));

        // Reload requested with two vectors in flight.
        p0 = pops[1];
        out_ready[1] = 1'b0;
        applyStimulus(1, 5'd9);
        applyStimulus(1, 5'd10);
        startCfg();
        for (int k = 0; k < 3; k++) begin
            checkOutput("drain_in_ready", 32'(in_ready_b), 0);
            checkOutput("drain_cfg_ready_b", 32'(cfg_ready_b), 0);
            @(posedge clk);
            #1;
        end
        out_ready[1] = 1'b1;
        waitCfgReady();
        checkOutput("inflight_pops", 32'(pops[1] - p0), 2);
        loadWords(1, DEPTH, 1'b0);
        checkOutput("load_done", 32'({cfg_ready_a, cfg_ready_b}), 0);
        applyStimulus(1, 5'd9);
        applyStimulus(0, 5'd9);
        waitDrain(1);
        waitDrain(0);
        checkOutput("new_tbl_b", 32'(out_data_b), 32'(tableWord(1, 9)));

        // Saturation on the 4-bit counter, then clear behaviour.
        loadTable(2, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1, IN_W'((k + 1) % 2));
        waitDrain(1);
        checkOutput("sat15", 32'(tog_b), 15);
        checkOutput("tog_model_b", 32'(tog_b), 32'(exp_tog[1]));
        toggle_clr[1] = 1'b1;
        @(posedge clk);
        #1;
        toggle_clr[1] = 1'b0;
        exp_tog[1] = 0;
        checkOutput("clr_idle", 32'(tog_b), 0);
        toggle_clr[0] = 1'b1;
        applyStimulus(0, 5'd1);
        toggle_clr[0] = 1'b0;
        waitDrain(0);
        checkOutput("clr_wins", 32'(tog_a), 0);
        applyStimulus(0, 5'd0);
        waitDrain(0);
        checkOutput("after_clr", 32'(tog_a), 28);

        // Reset in the middle of a reload.
        startCfg();
        waitCfgReady();
        loadWords(3, 10, 1'b0);
        checkOutput("mid_load_rdy", 32'(cfg_ready_a), 1);
        rst_n = 1'b0;
        #2;
        checkOutput("rst_abort_cfg", 32'({cfg_ready_a, cfg_ready_b}), 0);
        checkOutput("rst_abort_in", 32'({in_ready_a, in_ready_b}), 32'b11);
        applyReset();
        checkOutput("post_rst_cfg", 32'({cfg_ready_a, cfg_ready_b}), 0);
        applyStimulus(0, 5'd3);
        waitDrain(0);
        checkOutput("tbl_cleared", 32'(out_data_a), 0);
        loadTable(3, 1'b1);
        applyStimulus(0, 5'd0);
        applyStimulus(0, 5'd10);
        applyStimulus(0, 5'd31);
        applyStimulus(1, 5'd31);
        applyStimulus(1, 5'd4);
        waitDrain(0);
        waitDrain(1);
        checkOutput("reload_a", 32'(out_data_a), 32'(tableWord(3, 31)));
        checkOutput("reload_b", 32'(out_data_b), 32'(tableWord(3, 4)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pla_lut_engine.md
# pla_lut_engine

Parametrised, reloadable successor to the fixed 5-in/28-out PLA benchmarks in the power-aware synthesis train set. It holds an IN_W-input, OUT_W-output truth table in a register file loaded through a streaming configuration port. It evaluates input vectors through a valid/ready pipeline of LAT stages. A saturating output-toggle counter exposes switching activity to the RL power-estimation flow.

## Interface
Parameters:
- IN_W, 5, input vector width; table depth is 2^IN_W.
- OUT_W, 28, output word width.
- LAT, 1, pipeline latency in cycles; legal values are 1 and 2.
- CNT_W, 16, toggle counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  one-cycle request to reload the table.
- cfg_valid  in  1  configuration word valid.
- cfg_ready  out  1  high only in state LOAD.
- cfg_data  in  OUT_W  table word; words arrive in address order 0 .. 2^IN_W-1.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- in_data  in  IN_W  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  OUT_W  table[in_data]; holds its value between transfers.
- toggle_clr  in  1  synchronous clear of toggle_cnt.
- toggle_cnt  out  CNT_W  accumulated Hamming distance of successive out_data words.

## Operation
- FSM has three states: RUN, DRAIN and LOAD.
  - RUN: lookups proceed.
  - cfg_start in RUN moves the FSM to DRAIN.
  - DRAIN waits until every pipeline stage valid is 0, then moves to LOAD. This includes the case where the pipeline is already empty.
  - LOAD writes cfg_data to table[ptr] on each cfg_valid, then increments ptr.
  - The write at ptr = 2^IN_W-1 resets ptr to 0 and returns the FSM to RUN.
  - cfg_start in DRAIN or LOAD is ignored.
- in_ready = (state==RUN) & stage-1 ready.
  - Stage-k ready = ~valid_k | ready_{k+1}.
  - The ready of the last stage is out_ready.
- LAT=1: the table is read at acceptance, and the output register loads table[in_data].
- LAT=2: stage 1 registers in_data; the table is read when stage 1 advances into the output register.
- DRAIN guarantees that no in-flight vector sees a partially written table.
- Throughput is one vector per cycle with no bubbles under continuous valid/ready.
- out_data changes only when the output register loads. It does not change on backpressure or idle cycles (a power requirement).
- Toggle counting on each output-register load:
  - toggle_cnt += popcount(new_word ^ current out_data).
  - The counter saturates at 2^CNT_W-1.
  - toggle_clr forces 0 and wins over a simultaneous increment; that increment is discarded.
- Arithmetic: the popcount result width is clog2(OUT_W+1). The sum is computed at CNT_W+1 bits and then saturated.

## Timing
- Reset values (asynchronous assert, synchronous-safe deassert):
  - all table entries 0, ptr 0, state RUN;
  - all stage valids 0, so out_valid = 0;
  - out_data 0, toggle_cnt 0.
- cfg_ready = 0 and in_ready = 1 (RUN, pipeline empty).
- Latency from acceptance to out_valid:
  - LAT=1: the next cycle.
  - LAT=2: two cycles, with no stalls.
- cfg_start to cfg_ready:
  - one cycle when the pipeline is empty (RUN→DRAIN→LOAD);
  - otherwise, the cycle after the last stage valid clears, plus one.
- A full reload takes at least 2^IN_W cycles in LOAD. Gaps in cfg_valid are allowed.
- cfg_start and an in_valid handshake in the same cycle: the vector is accepted (in_ready was high in RUN), then the FSM enters DRAIN.
- Reset mid-LOAD aborts the load: the table is cleared to 0 and the partially loaded words are lost.
- An out_ready deassert stalls all stages. out_valid stays asserted and out_data stays stable until consumed.

## Test plan
- Reset, then lookup with no load: in_data 5'h1F accepted → out_valid one cycle later, out_data 0, toggle_cnt 0.
- Load table[a] = {23'b0, a}, then stream a = 0..31 back-to-back with out_ready high → 32 results in order, one per cycle, out_data = a. toggle_cnt = sum of popcount(a ^ (a-1)) for a = 1..31, with the first transfer counting popcount(0 ^ 0) = 0, giving 57.
- LAT=2, stall with out_ready low for 5 cycles while in_valid is held → in_ready drops after 2 vectors are held. out_data and toggle_cnt are unchanged during the stall, and no vector is lost or duplicated.
- Issue cfg_start with 2 vectors in flight → in_ready goes 0 and cfg_ready stays 0 until both are delivered. Both results come from the old table; subsequent results come from the new table.
- CNT_W=4, alternate table words 28'h0 and 28'hFFFFFFF → the counter saturates at 15. toggle_clr asserted on the same cycle as a load → toggle_cnt = 0.
- Assert rst_n low after 10 words in LOAD → state RUN, table reads 0, ptr 0, cfg_ready 0. A full reload afterwards succeeds.
